// File: rtl/data_sram_responder_pkg.sv
`default_nettype none
// =============================================================================
// data_sram_responder_pkg : shared types and constants for the data SRAM responder
// Revision: 1.0
// =============================================================================
package data_sram_responder_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  localparam int CNT_W           = 4;
  localparam int DEFAULT_LATENCY = 2;
  localparam int DEFAULT_DEPTH   = 2;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_sram_resp_fifo.sv
`default_nettype none
// =============================================================================
// data_sram_resp_fifo : in-order response queue of {data, countdown} entries
// Revision: 1.0
// =============================================================================
module data_sram_resp_fifo
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [CNT_W-1:0]  push_cnt,
  input  logic              pop,
  output logic              full,
  output logic              head_due,
  output logic [DATA_W-1:0] head_data
);

  localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_BITS = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_BITS-1:0] count;
  logic [DATA_W-1:0]   data_q [DEPTH];
  logic [CNT_W-1:0]    cd_q   [DEPTH];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        cd_q[i]   <= '0;
      end
    end else begin
      // Free slots may count down too; a push always overwrites the countdown.
      for (int i = 0; i < DEPTH; i++) begin
        if (cd_q[i] != '0) cd_q[i] <= cd_q[i] - 1'b1;
      end
      if (push) begin
        data_q[wr_ptr] <= push_data;
        cd_q[wr_ptr]   <= push_cnt;
        wr_ptr         <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full      = (count == CNT_BITS'(DEPTH));
  assign head_due  = (count != '0) && (cd_q[rd_ptr] == '0);
  assign head_data = data_q[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/data_sram_responder.sv
`default_nettype none
// =============================================================================
// data_sram_responder : multi-cycle SRAM-like data port slave, in-order replies
// Optional random address stalls: define DATA_SRAM_RAND_STALL_EN
// Revision: 1.0
// =============================================================================
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int DEPTH   = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       load_word;
  logic [31:0]       head_data;
  logic              full;
  logic              head_due;
  logic              accept;
  logic              stall;
  logic              unused_bits;

  assign word_idx    = addr[ADDR_W+1:2];
  assign load_word   = mem[word_idx];
  assign unused_bits = &{1'b0, size, addr[31:ADDR_W+2], addr[1:0]};

`ifdef DATA_SRAM_RAND_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr <= LFSR_SEED;
    else         lfsr <= lfsr_step(lfsr);
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Registered state only: a pop in this cycle does not free a slot early.
  assign addr_ok = !full && !stall;
  assign accept  = req && addr_ok;

  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  data_sram_resp_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (32)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (accept),
    .push_data (wr ? 32'h0 : load_word),
    .push_cnt  (CNT_W'(LATENCY - 1)),
    .pop       (head_due),
    .full      (full),
    .head_due  (head_due),
    .head_data (head_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_ok <= 1'b0;
      rdata   <= '0;
    end else begin
      data_ok <= head_due;
      if (head_due) rdata <= head_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_sram_responder.sv
`default_nettype none
// =============================================================================
// tb_data_sram_responder : directed + random bench with a transaction-level model
// Revision: 1.0
// =============================================================================
module tb_data_sram_responder;

  localparam int AW  = 10;
  localparam int LAT = 2;
  localparam int DEP = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  data_sram_responder #(
    .ADDR_W  (AW),
    .LATENCY (LAT),
    .DEPTH   (DEP)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .wr      (wr),
    .size    (size),
    .addr    (addr),
    .wstrb   (wstrb),
    .wdata   (wdata),
    .addr_ok (addr_ok),
    .data_ok (data_ok),
    .rdata   (rdata)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } resp_t;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] mmem [2**AW];
  resp_t       q [$];
  logic [15:0] lfsr_m;
  logic [31:0] exp_rd;
  logic        exp_dok;
  int          edge_n = 0;
  bit          last_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    lfsr_m  = 16'hACE1;
    exp_rd  = 32'h0;
    exp_dok = 1'b0;
  endtask

  // One clock: check addr_ok before the edge, advance the model, check the response after it.
  task automatic cycle();
    logic exp_aok;
    logic acc;
    resp_t e;
    exp_aok = (q.size() < DEP);
`ifdef DATA_SRAM_RAND_STALL_EN
    exp_aok = exp_aok && (lfsr_m[1:0] != 2'b00);
`endif
    check("addr_ok", {31'b0, addr_ok}, {31'b0, exp_aok});
    acc = req && exp_aok;
    @(posedge clk);
    edge_n++;
    if (acc) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) mmem[addr[AW+1:2]][8*b +: 8] = wdata[8*b +: 8];
        e.data = 32'h0;
      end else begin
        e.data = mmem[addr[AW+1:2]];
      end
      e.due = edge_n + LAT;
      q.push_back(e);
    end
    lfsr_m = lfsr_m[0] ? ((lfsr_m >> 1) ^ 16'hB400) : (lfsr_m >> 1);
    exp_dok = 1'b0;
    if (q.size() > 0 && q[0].due == edge_n) begin
      exp_dok = 1'b1;
      exp_rd  = q[0].data;
      void'(q.pop_front());
    end
    last_acc = acc;
    @(negedge clk);
    check("data_ok", {31'b0, data_ok}, {31'b0, exp_dok});
    check("rdata", rdata, exp_rd);
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    bit done;
    done  = 1'b0;
    req   = 1'b1;
    wr    = w;
    size  = 2'd2;
    addr  = a;
    wstrb = s;
    wdata = d;
    for (int t = 0; t < 50 && !done; t++) begin
      cycle();
      done = last_acc;
    end
    req = 1'b0;
    if (!done) begin
      compared++;
      mismatched++;
      $error("FAIL issue_timeout: observed no accept in 50 cycles, expected accept");
    end
  endtask

  initial begin
    resetn = 1'b0;
    req    = 1'b0;
    wr     = 1'b0;
    size   = 2'd0;
    addr   = 32'h0;
    wstrb  = 4'h0;
    wdata  = 32'h0;
    model_reset();

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_data_ok", {31'b0, data_ok}, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_addr_ok", {31'b0, addr_ok}, 32'h1);
    end
    resetn = 1'b1;
    idle(4);

    issue(1'b1, 32'h10, 4'hF, 32'h12345678);
    issue(1'b0, 32'h10, 4'h0, 32'h0);
    idle(4);
    check("store_load_word", rdata, 32'h12345678);

    issue(1'b1, 32'h20, 4'hF, 32'hAABBCCDD);
    issue(1'b1, 32'h20, 4'b0100, 32'h00EE0000);
    issue(1'b0, 32'h20, 4'h0, 32'h0);
    idle(4);
    check("byte_strobe_word", rdata, 32'hAAEECCDD);

    for (int i = 0; i < 4; i++)
      issue(1'b1, 32'h40 + 32'(4 * i), 4'hF, 32'h5A000000 + 32'(i));
    idle(3);
    for (int i = 0; i < 4; i++)
      issue(1'b0, 32'h40 + 32'(4 * i), 4'h0, 32'h0);
    idle(LAT + 3);
    check("full_queue_last", rdata, 32'h5A000003);

    for (int i = 0; i < 16; i++)
      issue(1'b1, 32'(4 * i), 4'hF, $urandom);
    for (int k = 0; k < 200; k++) begin
      req   = ($urandom_range(0, 9) < 6);
      wr    = 1'($urandom_range(0, 1));
      size  = 2'($urandom_range(0, 2));
      addr  = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      wstrb = 4'($urandom);
      wdata = $urandom;
      cycle();
    end
    idle(LAT + 3);

    issue(1'b1, 32'h80, 4'hF, 32'hCAFEF00D);
    idle(3);
    issue(1'b0, 32'h80, 4'h0, 32'h0);
    issue(1'b0, 32'h80, 4'h0, 32'h0);
    #2 resetn = 1'b0;
    #1;
    check("rstmid_data_ok", {31'b0, data_ok}, 32'h0);
    check("rstmid_rdata", rdata, 32'h0);
    check("rstmid_addr_ok", {31'b0, addr_ok}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    check("rstmid_hold_data_ok", {31'b0, data_ok}, 32'h0);
    resetn = 1'b1;
    model_reset();
    idle(5);
    issue(1'b0, 32'h80, 4'h0, 32'h0);
    idle(LAT + 2);
    check("post_reset_load", rdata, 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
